iter_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations, one radix-2 step per clock. It sits beside the combinational ALU in the multicycle datapath: the control FSM pulses `start`, waits on `busy`, and captures `result` when `done` pulses.

---
 rtl/iter_muldiv.sv | 164 ++++++++++++++++
 tb/tb_iter_muldiv.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M-extension ops.
// One multiplier bit or one quotient bit is resolved per clock. Operands are
// reduced to magnitudes on accept and the sign is re-applied in FIX.
module iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    // Multiply: {partial product high, multiplier shifting out the bottom}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [CW-1:0]     cnt_q;
    logic              neg_q;       // negate product / quotient in FIX
    logic              rneg_q;      // negate remainder in FIX
    logic              dbz_pend_q;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              dbz_q;

    // Accept-time decode: signedness, magnitudes and the divide special cases
    logic              is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, opnd_d;
    logic [2*XLEN-1:0] acc_d;
    logic              neg_d, rneg_d;

    always_comb begin
        is_div  = op[2];
        a_sgn   = is_div ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn   = is_div ? ~op[0] : ~op[1];
        a_neg   = a_sgn & A[XLEN-1];
        b_neg   = b_sgn & B[XLEN-1];
        mag_a   = a_neg ? -A : A;
        mag_b   = b_neg ? -B : B;
        b_zero  = (B == {XLEN{1'b0}});
        ovf     = is_div & ~op[0] & (A == MOST_NEG) & (B == {XLEN{1'b1}});
        special = is_div & (b_zero | ovf);
        acc_d   = {{XLEN{1'b0}}, mag_b};
        opnd_d  = mag_a;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = 1'b0;
        if (is_div) begin
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opnd_d = mag_b;
            rneg_d = a_neg;
            // Special cases preload the raw final {remainder, quotient}
            // and disable sign correction so FIX passes them through.
            if (b_zero) begin
                acc_d  = {A, {XLEN{1'b1}}};
                neg_d  = 1'b0;
                rneg_d = 1'b0;
            end else if (ovf) begin
                acc_d  = {{XLEN{1'b0}}, A};
                neg_d  = 1'b0;
                rneg_d = 1'b0;
            end
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] step_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            // Partial remainder < divisor, so bit XLEN of the difference
            // is exactly the borrow.
            if (!div_diff[XLEN])
                step_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
                step_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            step_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Final sign correction and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_q  ? -acc_q : acc_q;
        quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (op_q[2])
            fix_res = op_q[1] ? rem : quo;
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Control FSM with registered result/done/div_by_zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'b000;
            acc_q      <= {(2*XLEN){1'b0}};
            opnd_q     <= {XLEN{1'b0}};
            cnt_q      <= {CW{1'b0}};
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            result_q   <= {XLEN{1'b0}};
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        acc_q      <= acc_d;
                        opnd_q     <= opnd_d;
                        neg_q      <= neg_d;
                        rneg_q     <= rneg_d;
                        dbz_pend_q <= is_div & b_zero;
                        dbz_q      <= 1'b0;
                        cnt_q      <= CW'(XLEN);
                        state_q    <= special ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_q <= FIX;
                end
                FIX: begin
                    result_q <= fix_res;
                    dbz_q    <= dbz_pend_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: XLEN=32 and XLEN=8 instances checked
// against an arithmetic reference model of the M-extension operations.
module tb_iter_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0;
    logic [2:0]  op32 = 3'd0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] res32;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  res8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iter_muldiv #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .result(res32), .div_by_zero(dbz32)
    );

    iter_muldiv #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .result(res8), .div_by_zero(dbz8)
    );

    // Reference: plain 64-bit arithmetic on sign/zero-extended operands (w <= 32)
    function automatic logic [31:0] ref_model(int w, logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint mask, half, ua, ub, sa, sb, p, r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua ^ half) - half;
        sb = (ub ^ half) - half;
        r  = 0;
        case (o)
            3'd0: r = ua * ub;
            3'd1: begin p = sa * sb; r = longint'($unsigned(p) >> w); end
            3'd2: begin p = sa * ub; r = longint'($unsigned(p) >> w); end
            3'd3: begin p = ua * ub; r = longint'($unsigned(p) >> w); end
            3'd4: if (ub == 0) r = mask; else if (sa == -half && sb == -1) r = ua; else r = sa / sb;
            3'd5: if (ub == 0) r = mask; else r = ua / ub;
            3'd6: if (ub == 0) r = ua; else if (sa == -half && sb == -1) r = 0; else r = sa % sb;
            default: if (ub == 0) r = ua; else r = ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    // edges = number of rising edges after the accepting edge E0 at whose
    // end done is first seen: XLEN+1 for a normal op, 1 for a special divide.
    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic dbz, output int edges, output logic ovl);
        @(negedge clk);
        op32 = o; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
        edges = -1; ovl = 1'b0; res = '0; dbz = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (busy32 && done32) ovl = 1'b1;
            if (done32) begin
                edges = k; res = res32; dbz = dbz32;
                break;
            end
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic dbz, output int edges);
        @(negedge clk);
        op8 = o; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        edges = -1; res = '0; dbz = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                edges = k; res = res8; dbz = dbz8;
                break;
            end
        end
    endtask

    function automatic logic is_special(logic [2:0] o, logic [31:0] a, logic [31:0] b, int w);
        logic [31:0] mn, m1;
        mn = 32'(longint'(1) << (w - 1));
        m1 = 32'((longint'(1) << w) - 1);
        return o[2] && (b == 0 || (!o[0] && a == mn && b == m1));
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done32); end
        checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", res32); end
        checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", dbz32); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'h0) begin
            errors++; $display("FAIL reset_x8: got busy=%b done=%b res=%h want 0/0/00", busy8, done8, res8);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int          edges;
        logic        dz;
    } vec_t;

    task automatic test_directed();
        vec_t v[13];
        logic [31:0] r; logic dz, ovl; int e;
        v[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0};
        v[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0};
        v[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0};
        v[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0};
        v[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0};
        v[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0};
        v[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33, 1'b0};
        v[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33, 1'b0};
        v[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b1};
        v[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1,  1'b1};
        v[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0};
        v[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0};
        v[12] = '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1,  1'b1};
        for (int i = 0; i < 13; i++) begin
            run32(v[i].op, v[i].a, v[i].b, r, dz, e, ovl);
            checks++; if (r !== v[i].exp) begin errors++; $display("FAIL directed_result[%0d]: got %h want %h", i, r, v[i].exp); end
            checks++; if (e != v[i].edges) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, e, v[i].edges); end
            checks++; if (dz !== v[i].dz) begin errors++; $display("FAIL directed_dbz[%0d]: got %b want %b", i, dz, v[i].dz); end
            checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL directed_busy_done_overlap[%0d]: got %b want 0", i, ovl); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, exp; logic [2:0] o; logic dz, ovl; int e, ee;
        logic [31:0] picks[4];
        picks[0] = 32'h0; picks[1] = 32'h1; picks[2] = 32'hFFFFFFFF; picks[3] = 32'h80000000;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? picks[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 5) == 0) ? picks[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 28);
            exp = ref_model(32, o, a, b);
            ee  = is_special(o, a, b, 32) ? 1 : 33;
            run32(o, a, b, r, dz, e, ovl);
            checks++; if (r !== exp) begin errors++; $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", o, a, b, r, exp); end
            checks++; if (e != ee || dz !== (o[2] && b == 0) || ovl) begin
                errors++; $display("FAIL random_timing op=%0d: got edges=%0d dbz=%b ovl=%b want %0d/%b/0", o, e, dz, ovl, ee, o[2] && b == 0);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int seen = -1;
        @(negedge clk);
        op32 = 3'd5; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin
                @(negedge clk);
                op32 = 3'd0; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
            end
            @(posedge clk); #1;
            start32 = 1'b0;
            if (k == 10) begin
                checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy32); end
            end
            if (done32) begin seen = k; break; end
        end
        checks++; if (seen != 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", seen); end
        checks++; if (res32 !== 32'd142) begin errors++; $display("FAIL ignore_result: got %h want %h", res32, 32'd142); end
    endtask

    task automatic test_back_to_back();
        int seen = -1, seen2 = -1;
        @(negedge clk);
        op32 = 3'd0; a32 = 32'd1234; b32 = 32'd5678; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done32) begin seen = k; break; end
        end
        checks++; if (seen != 33 || res32 !== 32'd7006652) begin
            errors++; $display("FAIL b2b_first: got edges=%0d res=%h want 33/%h", seen, res32, 32'd7006652);
        end
        // still in the done cycle: request the next op
        op32 = 3'd7; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy32); end
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done32) begin seen2 = k; break; end
        end
        checks++; if (seen2 != 33 || res32 !== 32'd6) begin
            errors++; $display("FAIL b2b_second: got edges=%0d res=%h want 33/6", seen2, res32);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, exp; logic dz, ovl; int e; logic any_done = 1'b0;
        @(negedge clk);
        op32 = 3'd4; a32 = 32'd99999; b32 = 32'd13; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'h0) begin
            errors++; $display("FAIL midreset_outputs: got busy=%b done=%b res=%h want 0/0/0", busy32, done32, res32);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done32 || busy32) any_done = 1'b1;
        end
        checks++; if (any_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got activity=%b want 0", any_done); end
        exp = ref_model(32, 3'd4, 32'd1000, 32'hFFFFFFF9);
        run32(3'd4, 32'd1000, 32'hFFFFFFF9, r, dz, e, ovl);
        checks++; if (r !== exp || e != 33) begin
            errors++; $display("FAIL midreset_next_op: got res=%h edges=%0d want %h/33", r, e, exp);
        end
    endtask

    task automatic test_x8();
        logic [7:0] r, a, b, exp; logic [2:0] o; logic dz; int e, ee;
        run8(3'd2, 8'h80, 8'hFF, r, dz, e);
        checks++; if (r !== 8'h80 || e != 9) begin errors++; $display("FAIL x8_mulhsu: got %h edges=%0d want 80/9", r, e); end
        run8(3'd4, 8'h81, 8'h03, r, dz, e);
        checks++; if (r !== 8'hD6 || e != 9) begin errors++; $display("FAIL x8_div: got %h edges=%0d want d6/9", r, e); end
        run8(3'd5, 8'h05, 8'h00, r, dz, e);
        checks++; if (r !== 8'hFF || dz !== 1'b1 || e != 1) begin
            errors++; $display("FAIL x8_divzero: got %h dbz=%b edges=%0d want ff/1/1", r, dz, e);
        end
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            exp = 8'(ref_model(8, o, {24'd0, a}, {24'd0, b}));
            ee  = is_special(o, {24'd0, a}, {24'd0, b}, 8) ? 1 : 9;
            run8(o, a, b, r, dz, e);
            checks++; if (r !== exp || e != ee) begin
                errors++; $display("FAIL x8_random op=%0d a=%h b=%h: got %h edges=%0d want %h/%0d", o, a, b, r, e, exp, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_x8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
